// File: rtl/calc_pkg.sv
// Shared constants, state type and segment decoder for the calculator result display.
package calc_pkg;

  // 7-segment codes, bit order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;

  // Converter geometry: magnitude always handled as 16 bits, 5 BCD digits out
  localparam int MAG_W    = 16;
  localparam int BCD_W    = 20;
  localparam int NUM_POS  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2,
    SHOW = 2'd3
  } disp_state_t;

  // Decimal digit to segment pattern; non-decimal nibbles render blank
  function automatic logic [6:0] seg_of_bcd(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/calc_bin2bcd_seq.sv
// Sequential double-dabble: loads on start_i, then 16 add-3/shift steps.
// done_o is high during the final shift cycle, so bcd_o is complete on the
// cycle right after done_o.
module calc_bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   mag_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  logic [BCD_W-1:0] bcd_q;
  logic [MAG_W-1:0] mag_q;
  logic [4:0]       cnt_q;
  logic             busy_q;

  logic [BCD_W-1:0] bcd_adj;
  logic [MAG_W-1:0] mag_ext;

  assign mag_ext = MAG_W'(mag_i);

  // Add 3 to every nibble that is 5 or more before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Load on start, otherwise shift {bcd,mag} left once per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      mag_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bcd_q  <= '0;
      mag_q  <= mag_ext;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q  <= {bcd_adj[BCD_W-2:0], mag_q[MAG_W-1]};
      mag_q  <= {mag_q[MAG_W-2:0], 1'b0};
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd15) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 5'd15);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_result_display.sv
// Result display: valid/ready intake, BCD conversion, display buffer and
// multiplexed 6-position 7-segment scan (sign + 5 digits).
//
// Handshake: a result transfers on a rising edge where res_valid && res_ready.
// res_ready is high only in IDLE and SHOW; res_valid while res_ready is low is
// ignored and the producer keeps res_data/res_err stable until it transfers.
module calc_result_display
  import calc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_err,
  output logic [6:0]       seg,
  output logic [5:0]       digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  disp_state_t      state_q;
  logic             sign_q, err_q;

  // Display buffer; buf_valid_q low means everything renders blank
  logic [BCD_W-1:0] buf_bcd_q,   buf_bcd_d;
  logic             buf_sign_q,  buf_sign_d;
  logic             buf_err_q,   buf_err_d;
  logic             buf_valid_q, buf_valid_d;

  logic [PW-1:0]    presc_q;
  logic [2:0]       pos_q, pos_d;
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       sel_q, sel_d;
  logic             wrap;

  logic             transfer;
  logic [WIDTH-1:0] mag_abs;
  logic             core_busy, core_done;
  logic [BCD_W-1:0] core_bcd;

  assign res_ready = (state_q == IDLE) || (state_q == SHOW);
  assign transfer  = res_valid && res_ready;
  // Most negative value negates to itself, which is the right unsigned magnitude
  assign mag_abs   = res_data[WIDTH-1] ? (~res_data + WIDTH'(1)) : res_data;

  calc_bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (transfer),
    .mag_i   (mag_abs),
    .busy_o  (core_busy),
    .done_o  (core_done),
    .bcd_o   (core_bcd)
  );

  // Buffer next-state: only the DONE cycle loads a new result
  always_comb begin
    buf_bcd_d   = buf_bcd_q;
    buf_sign_d  = buf_sign_q;
    buf_err_d   = buf_err_q;
    buf_valid_d = buf_valid_q;
    if (state_q == DONE) begin
      buf_bcd_d   = core_bcd;
      buf_sign_d  = sign_q;
      buf_err_d   = err_q;
      buf_valid_d = 1'b1;
    end
  end

  // Handshake FSM, latched sign/err and display buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      buf_bcd_q   <= '0;
      buf_sign_q  <= 1'b0;
      buf_err_q   <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_bcd_q   <= buf_bcd_d;
      buf_sign_q  <= buf_sign_d;
      buf_err_q   <= buf_err_d;
      buf_valid_q <= buf_valid_d;
      case (state_q)
        IDLE, SHOW: begin
          if (transfer) begin
            sign_q  <= res_data[WIDTH-1];
            err_q   <= res_err;
            state_q <= CONV;
          end
        end
        CONV: begin
          // A core that is no longer busy can only mean the last shift happened
          if (core_done || !core_busy) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= SHOW;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wrap  = (presc_q == PW'(SCAN_DIV - 1));
  assign pos_d = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
  assign sel_d = 6'(1) << pos_d;

  // Pattern for the next position, taken from the next-state buffer so a
  // result landing on a scan wrap shows immediately
  always_comb begin
    seg_d = SEG_BLANK;
    if (buf_valid_d) begin
      if (buf_err_d) begin
        case (pos_d)
          3'd2:    seg_d = SEG_E;
          3'd1:    seg_d = SEG_R;
          3'd0:    seg_d = SEG_R;
          default: seg_d = SEG_BLANK;
        endcase
      end else begin
        case (pos_d)
          3'd0: seg_d = seg_of_bcd(buf_bcd_d[3:0]);
          3'd1: seg_d = (buf_bcd_d[19:4]  != '0) ? seg_of_bcd(buf_bcd_d[7:4])   : SEG_BLANK;
          3'd2: seg_d = (buf_bcd_d[19:8]  != '0) ? seg_of_bcd(buf_bcd_d[11:8])  : SEG_BLANK;
          3'd3: seg_d = (buf_bcd_d[19:12] != '0) ? seg_of_bcd(buf_bcd_d[15:12]) : SEG_BLANK;
          3'd4: seg_d = (buf_bcd_d[19:16] != '0) ? seg_of_bcd(buf_bcd_d[19:16]) : SEG_BLANK;
          3'd5: seg_d = (buf_sign_d && (buf_bcd_d != '0)) ? SEG_MINUS : SEG_BLANK;
          default: seg_d = SEG_BLANK;
        endcase
      end
    end
  end

  // Prescaler and scan; seg and digit_sel always move together
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pos_q   <= '0;
      seg_q   <= SEG_BLANK;
      sel_q   <= '0;
    end else if (wrap) begin
      presc_q <= '0;
      pos_q   <= pos_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign seg       = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with a short scan period.
module tb_calc_result_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [15:0] res_data = '0;
  logic        res_err = 1'b0;
  logic [6:0]  seg;
  logic [5:0]  digit_sel;

  int checks = 0;
  int errors = 0;

  // Expected frame, position p at bits [p*7 +: 7]
  logic [41:0] cur_frame = '0;

  calc_result_display #(.WIDTH(16), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] mk(input logic [6:0] p5, input logic [6:0] p4,
                                     input logic [6:0] p3, input logic [6:0] p2,
                                     input logic [6:0] p1, input logic [6:0] p0);
    return {p5, p4, p3, p2, p1, p0};
  endfunction

  function automatic int pos_of(input logic [5:0] s);
    int p;
    p = -1;
    for (int i = 0; i < 6; i++) if (s == (6'd1 << i)) p = i;
    return p;
  endfunction

  // Offer a result starting at a negedge; returns at the negedge after the transfer edge
  task automatic send(input logic [15:0] d, input logic e, input logic hold);
    int n;
    res_valid = 1'b1;
    res_data  = d;
    res_err   = e;
    n = 0;
    while (!res_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (res_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: res_ready=%b required 1 within 50 cycles", res_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) res_valid = 1'b0;
  endtask

  // Count busy cycles after a transfer; freshly scanned positions must still show old_frame
  task automatic wait_busy(input logic [41:0] old_frame, input string name);
    int n;
    int p;
    logic [5:0] prev;
    n = 0;
    prev = digit_sel;
    while (res_ready !== 1'b1 && n < 40) begin
      if (digit_sel !== prev) begin
        p = pos_of(digit_sel);
        checks++;
        if (p < 0 || seg !== old_frame[p*7 +: 7]) begin
          errors++;
          $display("FAIL %s_old_shown: sel=%b seg=%h required old frame %h", name, digit_sel, seg, old_frame);
        end
      end
      prev = digit_sel;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL %s_busy_len: busy=%0d cycles required 17", name, n);
    end
  endtask

  // Observe one full scan round that starts after the current moment
  task automatic capture_frame(input logic [41:0] exp, input string name);
    logic [5:0] seen;
    logic [5:0] prev;
    int p;
    int n;
    seen = '0;
    prev = digit_sel;
    n = 0;
    while (seen != 6'h3F && n < 80) begin
      @(negedge clk);
      n++;
      if (digit_sel !== prev) begin
        p = pos_of(digit_sel);
        checks++;
        if (p < 0) begin
          errors++;
          $display("FAIL %s_sel: digit_sel=%b required one-hot", name, digit_sel);
        end else begin
          seen[p] = 1'b1;
          if (seg !== exp[p*7 +: 7]) begin
            errors++;
            $display("FAIL %s_pos%0d: seg=%h required %h", name, p, seg, exp[p*7 +: 7]);
          end
        end
      end
      prev = digit_sel;
    end
    checks++;
    if (seen != 6'h3F) begin
      errors++;
      $display("FAIL %s_scan_timeout: positions seen=%b required 111111", name, seen);
    end
    cur_frame = exp;
  endtask

  task automatic convert_and_check(input logic [15:0] d, input logic e,
                                   input logic [41:0] exp, input string name);
    send(d, e, 1'b0);
    wait_busy(cur_frame, name);
    capture_frame(exp, name);
  endtask

  task automatic test_reset();
    logic [5:0] exp_sel;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b required 1", res_ready); end
    if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: %h required 00", seg); end
    if (digit_sel !== 6'h00) begin errors++; $display("FAIL reset_sel: %b required 000000", digit_sel); end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (digit_sel !== 6'h00) begin
        errors++;
        $display("FAIL reset_presc_edge%0d: digit_sel=%b required 000000", k, digit_sel);
      end
    end
    @(negedge clk);
    checks++;
    if (digit_sel !== 6'b000010) begin
      errors++;
      $display("FAIL reset_first_sel: digit_sel=%b required 000010", digit_sel);
    end
    for (int k = 2; k < 8; k++) begin
      repeat (4) @(negedge clk);
      exp_sel = 6'd1 << (k % 6);
      checks += 3;
      if (digit_sel !== exp_sel) begin
        errors++;
        $display("FAIL reset_scan_sel: digit_sel=%b required %b", digit_sel, exp_sel);
      end
      if (seg !== 7'h00) begin errors++; $display("FAIL reset_scan_seg: seg=%h required 00", seg); end
      if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_scan_ready: %b required 1", res_ready); end
    end
  endtask

  task automatic test_1234();
    convert_and_check(16'd1234, 1'b0, mk(7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66), "dec1234");
  endtask

  task automatic test_most_negative();
    convert_and_check(16'h8000, 1'b0, mk(7'h40, 7'h4F, 7'h5B, 7'h07, 7'h7D, 7'h7F), "neg32768");
  endtask

  task automatic test_err_and_zero();
    convert_and_check(16'd0, 1'b1, mk(7'h00, 7'h00, 7'h00, 7'h79, 7'h50, 7'h50), "err");
    convert_and_check(16'd0, 1'b0, mk(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F), "zero");
  endtask

  task automatic test_back_to_back();
    logic [41:0] frame_a;
    logic [41:0] frame_b;
    frame_a = mk(7'h00, 7'h00, 7'h00, 7'h00, 7'h66, 7'h5B);
    frame_b = mk(7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07);
    send(16'd42, 1'b0, 1'b1);
    res_data = 16'hFFF9;
    wait_busy(cur_frame, "b2b_first");
    @(negedge clk);
    checks++;
    if (res_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: res_ready=%b required 0 after first ready edge", res_ready);
    end
    res_valid = 1'b0;
    wait_busy(frame_a, "b2b_second");
    capture_frame(frame_b, "b2b_second");
  endtask

  task automatic test_mid_reset();
    send(16'd5555, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (res_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: %b required 1", res_ready); end
    if (seg !== 7'h00) begin errors++; $display("FAIL midrst_seg: %h required 00", seg); end
    if (digit_sel !== 6'h00) begin errors++; $display("FAIL midrst_sel: %b required 000000", digit_sel); end
    rst = 1'b0;
    capture_frame('0, "midrst_blank");
    convert_and_check(16'd99, 1'b0, mk(7'h00, 7'h00, 7'h00, 7'h00, 7'h6F, 7'h6F), "after_rst99");
  endtask

  initial begin
    test_reset();
    test_1234();
    test_most_negative();
    test_err_and_zero();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
